fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the fetch PC, issues word reads
// to instruction memory under a credit limit, buffers returned words with
// their PCs in an in-order queue and presents the head to decode. A redirect
// empties the queue, restarts fetch at a new PC and discards every response
// still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc   [FIFO_DEPTH];
  logic [31:0]   q_inst [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale;

  logic [CW:0]   in_use;
  logic [31:0]   redirect_base;
  logic          accept;
  logic          pop;
  logic          push;

  // Handshake decode and output muxing; request credit depends on registers only.
  always_comb begin
    in_use           = {1'b0, outstanding} + {1'b0, count};
    redirect_base    = redirect_pc_i & 32'hFFFF_FFFC;
    imem_req_valid_o = !rst_i && !redirect_i && (in_use < (CW+1)'(FIFO_DEPTH));
    imem_req_addr_o  = fetch_pc;
    accept           = imem_req_valid_o && imem_req_ready_i;
    inst_valid_o     = !rst_i && (count != '0);
    pop              = inst_valid_o && inst_ready_i;
    push             = imem_rsp_valid_i && !redirect_i && (stale == '0);
    inst_data_o      = rst_i ? '0 : q_inst[head];
    inst_pc_o        = rst_i ? '0 : q_pc[head];
  end

  // Control state: fetch/response PCs, queue pointers, in-flight and stale counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
        // Everything still in flight after this cycle's response belongs to the old stream.
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        stale    <= outstanding - CW'(imem_rsp_valid_i);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          tail    <= tail + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) head <= head + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
        if (imem_rsp_valid_i && (stale != '0)) stale <= stale - CW'(1);
      end
    end
  end

  // Queue storage: write the kept response together with its PC.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= imem_rsp_data_i;
    end
  end

  // Credit must keep a push from ever landing in a full queue.
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && (count == CW'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with directed and randomized memory,
// decode and redirect traffic. A reference model tracks memory requests by
// stream epoch and the expected instruction queue as a list of PCs.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_data_o;
  logic [31:0] inst_pc_o;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_data_o      (inst_data_o),
    .inst_pc_o        (inst_pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] mq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned epoch    = 0;
  int unsigned lat      = 1;
  int unsigned rdy_mode = 0;
  int unsigned req_mode = 0;
  logic        rsp_rand = 1'b0;
  logic        toggle   = 1'b0;
  logic        capture  = 1'b0;
  logic [31:0] first_pc = '0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] exp_addr = RPC;
  int unsigned n_acc = 0;
  int unsigned n_pop = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: drive inputs after the falling edge, check, update model.
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc);
    logic        rsp;
    logic        exp_rv;
    int unsigned l;
    mreq_t       e;
    @(negedge clk);
    rst_i         = rst;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    case (rdy_mode)
      0:       inst_ready_i = 1'b1;
      1:       inst_ready_i = logic'($urandom_range(0, 1));
      default: inst_ready_i = 1'b0;
    endcase
    case (req_mode)
      0:       imem_req_ready_i = 1'b1;
      1:       begin toggle = ~toggle; imem_req_ready_i = toggle; end
      default: imem_req_ready_i = logic'($urandom_range(0, 1));
    endcase
    rsp = 1'b0;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc)
      rsp = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp ? mem_word(memq[0].addr) : $urandom();
    #1;
    if (rst) begin
      check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_inst_data", inst_data_o, 32'd0);
      check("rst_inst_pc", inst_pc_o, 32'd0);
      memq.delete();
      mq.delete();
      epoch++;
      exp_addr = RPC;
    end else begin
      exp_rv = !redir && ((memq.size() + mq.size()) < DEPTH);
      check("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
      check("inst_valid", 32'(inst_valid_o), 32'(mq.size() != 0));
      if (inst_valid_o && inst_ready_i && mq.size() > 0) begin
        check("inst_pc", inst_pc_o, mq[0]);
        check("inst_data", inst_data_o, mem_word(mq[0]));
        last_pop_pc = inst_pc_o;
        if (capture) begin first_pc = inst_pc_o; capture = 1'b0; end
        void'(mq.pop_front());
        n_pop++;
      end
      if (rsp) begin
        e = memq.pop_front();
        if (!redir && e.epoch == epoch) mq.push_back(e.addr);
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        check("req_addr", imem_req_addr_o, exp_addr);
        l = (lat == 0) ? $urandom_range(1, 4) : lat;
        memq.push_back('{imem_req_addr_o, epoch, cyc + l});
        exp_addr += 32'd4;
        n_acc++;
      end
      if (redir) begin
        epoch++;
        mq.delete();
        exp_addr = rpc & 32'hFFFF_FFFC;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0);
    n_acc = 0;
    n_pop = 0;
  endtask

  initial begin
    logic        rd;
    logic        rs;
    logic [31:0] p;
    rst_i            = 1'b1;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    inst_ready_i     = 1'b0;

    do_reset();
    do_reset();

    // Streaming with 1-cycle memory: first word visible two cycles after release.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check("t1_pops", n_pop, 32'd8);

    // Decode stalled: exactly DEPTH requests, head held at reset PC.
    rdy_mode = 2;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check("t2_reqs", n_acc, DEPTH);
    check("t2_head_pc", inst_pc_o, RPC);

    // Memory ready toggling every cycle.
    rdy_mode = 0;
    req_mode = 1;
    toggle   = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
    check("t3_reqs", n_acc, 32'd10);

    // 3-cycle memory, two in flight at the redirect.
    req_mode = 0;
    lat      = 3;
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("t4_inflight", n_acc, 32'd2);
    step(1'b0, 1'b1, 32'h0000_0103);
    capture = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);
    check("t4_first_pc", first_pc, 32'h0000_0100);

    // Redirect in a cycle that also has a response and a pop.
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    check("t5_pre_rsp", 32'(imem_rsp_valid_i), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, '0);
    check("t5_empty", 32'(inst_valid_o), 32'd0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    check("t6_wrap", last_pop_pc, 32'h0000_0010);

    // Randomized traffic with redirects and occasional mid-run reset.
    lat      = 0;
    rdy_mode = 1;
    req_mode = 2;
    rsp_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rd = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 499) == 0);
      p  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step(rs, rd && !rs, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
